// File: rtl/key_encoder_pkg.sv
// key_encoder_pkg: protobuf wire-type codes, encoder FSM states and varint
// byte-count helpers shared by the key encoder and its serializer.
package key_encoder_pkg;

  localparam logic [2:0] WT_VARINT = 3'd0;
  localparam logic [2:0] WT_I64    = 3'd1;
  localparam logic [2:0] WT_LEN    = 3'd2;
  localparam logic [2:0] WT_SGROUP = 3'd3;
  localparam logic [2:0] WT_EGROUP = 3'd4;
  localparam logic [2:0] WT_I32    = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KEY,
    ST_LEN
  } enc_state_t;

  // Codes 6 and 7 are unassigned in the protobuf wire format.
  function automatic logic wire_type_ok(input logic [2:0] wt);
    return wt inside {WT_VARINT, WT_I64, WT_LEN, WT_SGROUP, WT_EGROUP, WT_I32};
  endfunction

  function automatic int key_max_bytes(input int field_w);
    return (field_w + 3 + 6) / 7;
  endfunction

  function automatic int len_max_bytes(input int len_w);
    return (len_w + 6) / 7;
  endfunction

endpackage

// File: rtl/key_encoder_if.sv
// key_encoder_if: request handshake plus the outgoing header byte stream.
interface key_encoder_if #(
  parameter int FIELD_W = 29,
  parameter int LEN_W   = 16
);
  logic               io_in_valid;
  logic               io_in_ready;
  logic [FIELD_W-1:0] io_field_number;
  logic [2:0]         io_wire_type;
  logic [LEN_W-1:0]   io_value_size;
  logic               io_out_valid;
  logic               io_out_ready;
  logic [7:0]         io_out_data;
  logic               io_out_last;
  logic               io_done;
  logic [7:0]         io_bytes_written;
  logic               io_error;

  modport slave (
    input  io_in_valid, io_field_number, io_wire_type, io_value_size, io_out_ready,
    output io_in_ready, io_out_valid, io_out_data, io_out_last, io_done,
           io_bytes_written, io_error
  );

  modport master (
    output io_in_valid, io_field_number, io_wire_type, io_value_size, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_data, io_out_last, io_done,
           io_bytes_written, io_error
  );
endinterface

// File: rtl/key_encoder_varint_serializer.sv
// key_encoder_varint_serializer: holds a value and presents it as varint
// bytes, LSB group first, shifting one 7-bit group out per advance.
module key_encoder_varint_serializer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         advance,
  output logic [7:0]   byte_data,
  output logic         last
);

  logic [W-1:0] value_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= load_value;
    end else if (advance) begin
      value_q <= value_q >> 7;
    end
  end

  // A zero value still yields one byte: 0x00 with last set.
  assign last      = ~|value_q[W-1:7];
  assign byte_data = {~last, value_q[6:0]};

endmodule

// File: rtl/key_encoder.sv
// key_encoder: serializes {field_number, wire_type} as a varint key, followed
// by a varint length for wire type 2 when KEY_ENCODER_LEN_EN is defined.
module key_encoder
  import key_encoder_pkg::*;
#(
  parameter int FIELD_W = 29,
  parameter int LEN_W   = 16
) (
  input logic          clock,
  input logic          reset,
  key_encoder_if.slave bus
);

  localparam int KEY_W = FIELD_W + 3;
  localparam int SER_W = (KEY_W > LEN_W) ? KEY_W : LEN_W;
`ifdef KEY_ENCODER_LEN_EN
  localparam int HDR_BYTES = key_max_bytes(FIELD_W) + len_max_bytes(LEN_W);
`else
  localparam int HDR_BYTES = key_max_bytes(FIELD_W);
`endif

  enc_state_t       state;
  logic             error_q;
  logic [7:0]       byte_count;
  logic [7:0]       next_count;
  logic             accept;
  logic             bad_request;
  logic             transfer;
  logic             final_byte;
  logic             load;
  logic             advance;
  logic [SER_W-1:0] load_value;
  logic [7:0]       ser_byte;
  logic             ser_last;

`ifdef KEY_ENCODER_LEN_EN
  logic             len_pending;
  logic [LEN_W-1:0] len_q;
`else
  logic             unused_value_size;
  assign unused_value_size = ^bus.io_value_size;
`endif

  assign accept      = bus.io_in_valid && (state == ST_IDLE);
  assign bad_request = !wire_type_ok(bus.io_wire_type) || (bus.io_field_number == '0);
  assign transfer    = (state != ST_IDLE) && bus.io_out_ready;
  assign next_count  = (byte_count == 8'(HDR_BYTES)) ? byte_count : byte_count + 8'd1;

`ifdef KEY_ENCODER_LEN_EN
  assign final_byte = ser_last && ((state == ST_LEN) || !len_pending);
`else
  assign final_byte = ser_last;
`endif

  // The single serializer is loaded with the key on accept and reloaded with
  // the length on the final key byte, so key and length run without a bubble.
  always_comb begin
    load       = 1'b0;
    load_value = '0;
    if (accept && !bad_request) begin
      load       = 1'b1;
      load_value = SER_W'({bus.io_field_number, bus.io_wire_type});
    end
`ifdef KEY_ENCODER_LEN_EN
    else if (transfer && (state == ST_KEY) && ser_last && len_pending) begin
      load       = 1'b1;
      load_value = SER_W'(len_q);
    end
`endif
  end

  assign advance = transfer && !load;

  key_encoder_varint_serializer #(
    .W(SER_W)
  ) u_varint_serializer (
    .clk       (clock),
    .rst_n     (reset),
    .load      (load),
    .load_value(load_value),
    .advance   (advance),
    .byte_data (ser_byte),
    .last      (ser_last)
  );

  // Header sequencing: accept or reject in IDLE, then stream key (and length).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      error_q    <= 1'b0;
      byte_count <= 8'd0;
`ifdef KEY_ENCODER_LEN_EN
      len_pending <= 1'b0;
      len_q       <= '0;
`endif
    end else begin
      error_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (bad_request) begin
              error_q <= 1'b1;
            end else begin
              state      <= ST_KEY;
              byte_count <= 8'd0;
`ifdef KEY_ENCODER_LEN_EN
              len_pending <= (bus.io_wire_type == WT_LEN);
              len_q       <= bus.io_value_size;
`endif
            end
          end
        end
        ST_KEY: begin
          if (transfer) begin
            byte_count <= next_count;
            if (ser_last) begin
`ifdef KEY_ENCODER_LEN_EN
              state <= len_pending ? ST_LEN : ST_IDLE;
`else
              state <= ST_IDLE;
`endif
            end
          end
        end
`ifdef KEY_ENCODER_LEN_EN
        ST_LEN: begin
          if (transfer) begin
            byte_count <= next_count;
            if (ser_last) begin
              state <= ST_IDLE;
            end
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.io_in_ready      = (state == ST_IDLE);
  assign bus.io_out_valid     = (state != ST_IDLE);
  assign bus.io_out_data      = bus.io_out_valid ? ser_byte : 8'h00;
  assign bus.io_out_last      = bus.io_out_valid && final_byte;
  assign bus.io_done          = bus.io_out_valid && bus.io_out_ready && final_byte;
  assign bus.io_bytes_written = bus.io_done ? byte_count + 8'd1 : 8'd0;
  assign bus.io_error         = error_q;

endmodule

// File: tb/tb_key_encoder.sv
// tb_key_encoder: scoreboard bench for key_encoder; expected header bytes are
// queued as each request is driven and compared as the DUT transfers bytes.
module tb_key_encoder;

`ifdef KEY_ENCODER_LEN_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  int   checks;
  int   errors;
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];

  always #5 clock = ~clock;

  key_encoder_if #(.FIELD_W(29), .LEN_W(16)) bus ();

  key_encoder #(.FIELD_W(29), .LEN_W(16)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Drive one request; returns 1 ns after the accepting edge (cycle N+1).
  task automatic send(input logic [28:0] f, input logic [2:0] wt, input logic [15:0] sz);
    @(negedge clock);
    bus.io_in_valid     = 1'b1;
    bus.io_field_number = f;
    bus.io_wire_type    = wt;
    bus.io_value_size   = sz;
    @(posedge clock);
    #1;
    bus.io_in_valid = 1'b0;
  endtask

  // Reference varint encoding of a header, pushed onto the scoreboard.
  task automatic push_expected(input logic [28:0] f, input logic [2:0] wt, input logic [15:0] sz, output int n);
    logic [31:0] v;
    logic [8:0]  tail;
    n = 0;
    v = {f, wt};
    do begin
      exp_q.push_back({1'b0, ((v >> 7) != 0), v[6:0]});
      v = v >> 7;
      n++;
    end while (v != 0);
    if (LEN_EN && wt == 3'd2) begin
      v = {16'd0, sz};
      do begin
        exp_q.push_back({1'b0, ((v >> 7) != 0), v[6:0]});
        v = v >> 7;
        n++;
      end while (v != 0);
    end
    tail = exp_q.pop_back();
    exp_q.push_back(tail | 9'h100);
  endtask

  // Collect transferred bytes into obs_q (no checking here), bounded in cycles.
  task automatic collect(input bit stall, input int max_bytes, output int cycles, output int first_cyc,
                         output int unstable, output int dones, output int done_bad, output int bw,
                         output bit timed_out);
    int         n;
    bit         held;
    bit         rdy;
    logic [8:0] hv;
    n = 0; held = 0; hv = '0; cycles = 0; first_cyc = -1;
    unstable = 0; dones = 0; done_bad = 0; bw = 0; timed_out = 1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      rdy = stall ? ((c == 0) ? 1'b0 : ($urandom_range(0, 2) != 0)) : 1'b1;
      bus.io_out_ready = rdy;
      #1;
      if (bus.io_done) begin
        dones++;
        bw = int'(bus.io_bytes_written);
        if (!(bus.io_out_valid && rdy && bus.io_out_last)) done_bad++;
      end
      if (bus.io_out_valid) begin
        if (first_cyc < 0) first_cyc = c;
        if (held && ({bus.io_out_last, bus.io_out_data} !== hv)) unstable++;
        if (rdy) begin
          obs_q.push_back({bus.io_out_last, bus.io_out_data});
          n++;
          held = 0;
          if (bus.io_out_last || n == max_bytes) begin
            cycles    = c - first_cyc + 1;
            timed_out = 0;
            break;
          end
        end else begin
          held = 1;
          hv   = {bus.io_out_last, bus.io_out_data};
        end
      end else if (held) begin
        unstable++;
      end
    end
    bus.io_out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (bus.io_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", bus.io_in_ready); end
    checks++; if (bus.io_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.io_out_valid); end
    checks++; if (bus.io_out_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_out_data got %h want 00", bus.io_out_data); end
    checks++; if ({bus.io_out_last, bus.io_done, bus.io_error} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b want 000", {bus.io_out_last, bus.io_done, bus.io_error}); end
    checks++; if (bus.io_bytes_written !== 8'd0) begin errors++; $display("[TB] FAIL reset_bytes_written got %0d want 0", bus.io_bytes_written); end
    reset = 1'b1;
    @(negedge clock);
    #1;
    checks++; if ({bus.io_in_ready, bus.io_out_valid} !== 2'b10) begin errors++; $display("[TB] FAIL post_reset_idle got %b want 10", {bus.io_in_ready, bus.io_out_valid}); end
  endtask

  task automatic test_single_byte();
    int cycles, first, unst, dones, dbad, bw;
    bit to;
    logic [8:0] e, o;
    exp_q.push_back(9'h108);
    send(29'd1, 3'd0, 16'd0);
    collect(1'b0, 0, cycles, first, unst, dones, dbad, bw, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 9'h1FF;
      checks++; if (o !== e) begin errors++; $display("[TB] FAIL single_byte got %h want %h", o, e); end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL single_extra got %0d want 0", obs_q.size()); obs_q.delete(); end
    checks++; if (to) begin errors++; $display("[TB] FAIL single_timeout got 1 want 0"); end
    checks++; if (first != 0) begin errors++; $display("[TB] FAIL single_latency got %0d want 0", first); end
    checks++; if (dones != 1 || dbad != 0) begin errors++; $display("[TB] FAIL single_done got %0d/%0d want 1/0", dones, dbad); end
    checks++; if (bw != 1) begin errors++; $display("[TB] FAIL single_bytes_written got %0d want 1", bw); end
    @(negedge clock);
    #1;
    checks++; if ({bus.io_in_ready, bus.io_out_valid} !== 2'b10) begin errors++; $display("[TB] FAIL single_ready_after got %b want 10", {bus.io_in_ready, bus.io_out_valid}); end
  endtask

  task automatic test_len_field();
    int cycles, first, unst, dones, dbad, bw, want_n;
    bit to;
    logic [8:0] e, o;
    if (LEN_EN) begin
      exp_q.push_back(9'h0B2); exp_q.push_back(9'h009); exp_q.push_back(9'h0AC); exp_q.push_back(9'h102);
      want_n = 4;
    end else begin
      exp_q.push_back(9'h0B2); exp_q.push_back(9'h109);
      want_n = 2;
    end
    send(29'd150, 3'd2, 16'd300);
    collect(1'b0, 0, cycles, first, unst, dones, dbad, bw, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 9'h1FF;
      checks++; if (o !== e) begin errors++; $display("[TB] FAIL len_field_byte got %h want %h", o, e); end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL len_field_extra got %0d want 0", obs_q.size()); obs_q.delete(); end
    checks++; if (to) begin errors++; $display("[TB] FAIL len_field_timeout got 1 want 0"); end
    checks++; if (cycles != want_n) begin errors++; $display("[TB] FAIL len_field_bubbles got %0d cycles want %0d", cycles, want_n); end
    checks++; if (dones != 1 || dbad != 0) begin errors++; $display("[TB] FAIL len_field_done got %0d/%0d want 1/0", dones, dbad); end
    checks++; if (bw != want_n) begin errors++; $display("[TB] FAIL len_field_bytes_written got %0d want %0d", bw, want_n); end
  endtask

  task automatic test_max_field();
    int cycles, first, unst, dones, dbad, bw;
    bit to;
    logic [8:0] e, o;
    exp_q.push_back(9'h0FD); exp_q.push_back(9'h0FF); exp_q.push_back(9'h0FF);
    exp_q.push_back(9'h0FF); exp_q.push_back(9'h10F);
    send(29'h1FFF_FFFF, 3'd5, 16'd0);
    collect(1'b0, 0, cycles, first, unst, dones, dbad, bw, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 9'h1FF;
      checks++; if (o !== e) begin errors++; $display("[TB] FAIL max_field_byte got %h want %h", o, e); end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL max_field_extra got %0d want 0", obs_q.size()); obs_q.delete(); end
    checks++; if (to || cycles != 5) begin errors++; $display("[TB] FAIL max_field_cycles got %0d want 5", cycles); end
    checks++; if (bw != 5) begin errors++; $display("[TB] FAIL max_field_bytes_written got %0d want 5", bw); end
  endtask

  task automatic test_stall();
    int cycles, first, unst, dones, dbad, bw;
    bit to;
    logic [8:0] e, o;
    exp_q.push_back(9'h0FD); exp_q.push_back(9'h0FF); exp_q.push_back(9'h0FF);
    exp_q.push_back(9'h0FF); exp_q.push_back(9'h10F);
    send(29'h1FFF_FFFF, 3'd5, 16'd0);
    collect(1'b1, 0, cycles, first, unst, dones, dbad, bw, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 9'h1FF;
      checks++; if (o !== e) begin errors++; $display("[TB] FAIL stall_byte got %h want %h", o, e); end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL stall_extra got %0d want 0", obs_q.size()); obs_q.delete(); end
    checks++; if (to) begin errors++; $display("[TB] FAIL stall_timeout got 1 want 0"); end
    checks++; if (unst != 0) begin errors++; $display("[TB] FAIL stall_stability got %0d changes want 0", unst); end
    checks++; if (dones != 1 || dbad != 0) begin errors++; $display("[TB] FAIL stall_done got %0d/%0d want 1/0", dones, dbad); end
    checks++; if (bw != 5) begin errors++; $display("[TB] FAIL stall_bytes_written got %0d want 5", bw); end
  endtask

  task automatic test_error();
    logic [28:0] fields[3] = '{29'd3, 29'd3, 29'd0};
    logic [2:0]  wts[3]    = '{3'd6, 3'd7, 3'd0};
    for (int i = 0; i < 3; i++) begin
      send(fields[i], wts[i], 16'd5);
      checks++; if ({bus.io_error, bus.io_in_ready, bus.io_out_valid} !== 3'b110) begin errors++; $display("[TB] FAIL error_pulse_%0d got %b want 110", i, {bus.io_error, bus.io_in_ready, bus.io_out_valid}); end
      for (int k = 0; k < 2; k++) begin
        @(posedge clock);
        #1;
        checks++; if ({bus.io_error, bus.io_in_ready, bus.io_out_valid} !== 3'b010) begin errors++; $display("[TB] FAIL error_after_%0d got %b want 010", i, {bus.io_error, bus.io_in_ready, bus.io_out_valid}); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    int cycles, first, unst, dones, dbad, bw, n;
    bit to;
    logic [8:0] e, o;
    exp_q.push_back(9'h0B2);
    exp_q.push_back(LEN_EN ? 9'h009 : 9'h109);
    send(29'd150, 3'd2, 16'd300);
    collect(1'b0, 2, cycles, first, unst, dones, dbad, bw, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 9'h1FF;
      checks++; if (o !== e) begin errors++; $display("[TB] FAIL abort_prefix got %h want %h", o, e); end
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checks++; if ({bus.io_out_valid, bus.io_out_last, bus.io_done, bus.io_error} !== 4'b0000) begin errors++; $display("[TB] FAIL abort_flags got %b want 0000", {bus.io_out_valid, bus.io_out_last, bus.io_done, bus.io_error}); end
    checks++; if ({bus.io_out_data, bus.io_bytes_written} !== 16'h0000) begin errors++; $display("[TB] FAIL abort_data got %h want 0000", {bus.io_out_data, bus.io_bytes_written}); end
    checks++; if (bus.io_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_in_ready got %b want 1", bus.io_in_ready); end
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      #1;
      checks++; if ({bus.io_out_valid, bus.io_done} !== 2'b00) begin errors++; $display("[TB] FAIL abort_quiet got %b want 00", {bus.io_out_valid, bus.io_done}); end
    end
    push_expected(29'd150, 3'd2, 16'd300, n);
    send(29'd150, 3'd2, 16'd300);
    collect(1'b0, 0, cycles, first, unst, dones, dbad, bw, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 9'h1FF;
      checks++; if (o !== e) begin errors++; $display("[TB] FAIL fresh_byte got %h want %h", o, e); end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL fresh_extra got %0d want 0", obs_q.size()); obs_q.delete(); end
    checks++; if (to || bw != n) begin errors++; $display("[TB] FAIL fresh_bytes_written got %0d want %0d", bw, n); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  wts[4] = '{3'd0, 3'd2, 3'd1, 3'd5};
    logic [28:0] f;
    logic [15:0] sz;
    int cycles, first, unst, dones, dbad, bw, n;
    bit to;
    logic [8:0] e, o;
    for (int i = 0; i < 4; i++) begin
      f  = 29'($urandom_range(1, 32'h1FFF_FFFF));
      sz = 16'($urandom_range(0, 65535));
      push_expected(f, wts[i], sz, n);
      send(f, wts[i], sz);
      bus.io_in_valid     = 1'b1;
      bus.io_field_number = 29'd7;
      bus.io_wire_type    = 3'd0;
      collect(1'b0, 0, cycles, first, unst, dones, dbad, bw, to);
      checks++; if (bus.io_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_busy_%0d got %b want 0", i, bus.io_in_ready); end
      bus.io_in_valid = 1'b0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 9'h1FF;
        checks++; if (o !== e) begin errors++; $display("[TB] FAIL b2b_byte_%0d got %h want %h", i, o, e); end
      end
      checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL b2b_extra_%0d got %0d want 0", i, obs_q.size()); obs_q.delete(); end
      checks++; if (to || first != 0 || bw != n) begin errors++; $display("[TB] FAIL b2b_timing_%0d got first %0d bw %0d want 0 %0d", i, first, bw, n); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks               = 0;
    errors               = 0;
    reset                = 1'b0;
    bus.io_in_valid      = 1'b0;
    bus.io_field_number  = '0;
    bus.io_wire_type     = '0;
    bus.io_value_size    = '0;
    bus.io_out_ready     = 1'b1;
    test_reset();
    test_single_byte();
    test_len_field();
    test_max_field();
    test_stall();
    test_error();
    test_reset_midstream();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
